// File: rtl/io_input_cond_pkg.sv
// Shared IO constants and the per-channel debounce action encoding.
package io_input_cond_pkg;
  localparam int IO_WIDTH           = 6;
  localparam int IO_DEBOUNCE_CYCLES = 4;
  localparam int IO_NUM_CH          = 3;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_LOAD,
    DB_COUNT,
    DB_ACCEPT
  } db_act_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction
endpackage

// File: rtl/io_debounce_ch.sv
// One switch channel: two-flop synchronizer, candidate/stable registers and
// a stability counter; chg pulses for one cycle when the stable value moves.
module io_debounce_ch
  import io_input_cond_pkg::*;
#(
  parameter int WIDTH           = IO_WIDTH,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] q,
  output logic             chg
);
  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2, cand, stab;
  logic [CW-1:0]    cnt;
  db_act_e          act;

  // Any movement of the synchronized level restarts the count.
  always_comb begin
    act = DB_IDLE;
    if (s2 != cand)        act = DB_LOAD;
    else if (cand != stab) act = (cnt == CNT_LAST) ? DB_ACCEPT : DB_COUNT;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      stab <= '0;
      cnt  <= '0;
      chg  <= 1'b0;
    end else begin
      s1  <= sw;
      s2  <= s1;
      chg <= 1'b0;
      case (act)
        DB_LOAD: begin
          cand <= s2;
          cnt  <= '0;
        end
        DB_COUNT: cnt <= cnt + CW'(1);
        DB_ACCEPT: begin
          stab <= cand;
          cnt  <= '0;
          chg  <= 1'b1;
        end
        DB_IDLE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  assign q = stab;
endmodule

// File: rtl/io_input_cond.sv
// Debounced conditioning of three board switch banks feeding the CPU input
// ports; chg/any_chg flag a new debounced value.
module io_input_cond
  import io_input_cond_pkg::*;
#(
  parameter int WIDTH           = IO_WIDTH,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw0,
  input  logic [WIDTH-1:0] sw1,
  input  logic [WIDTH-1:0] sw2,
  output logic [WIDTH-1:0] in_port0,
  output logic [WIDTH-1:0] in_port1,
  output logic [WIDTH-1:0] in_port2,
  output logic [2:0]       chg,
  output logic             any_chg
);
  logic [IO_NUM_CH-1:0][WIDTH-1:0] sw_v, q_v;

  assign sw_v = {sw2, sw1, sw0};

  io_debounce_ch #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch [IO_NUM_CH-1:0] (
    .clock (clock),
    .resetn(resetn),
    .sw    (sw_v),
    .q     (q_v),
    .chg   (chg)
  );

  assign in_port0 = q_v[0];
  assign in_port1 = q_v[1];
  assign in_port2 = q_v[2];
  // OR of registered pulses only; nothing from sw reaches an output combinationally.
  assign any_chg  = |chg;
endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond: default debounce (4) plus a DEBOUNCE_CYCLES=1 instance.
module tb_io_input_cond;
  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] sw0, sw1, sw2, in_port0, in_port1, in_port2;
  logic [2:0] chg;
  logic       any_chg;
  logic [5:0] swb0, swb1, swb2, ib0, ib1, ib2;
  logic [2:0] chgb;
  logic       anyb;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses [3];

  io_input_cond dut (
    .clock(clock), .resetn(resetn),
    .sw0(sw0), .sw1(sw1), .sw2(sw2),
    .in_port0(in_port0), .in_port1(in_port1), .in_port2(in_port2),
    .chg(chg), .any_chg(any_chg)
  );

  io_input_cond #(.WIDTH(6), .DEBOUNCE_CYCLES(1)) dut_b (
    .clock(clock), .resetn(resetn),
    .sw0(swb0), .sw1(swb1), .sw2(swb2),
    .in_port0(ib0), .in_port1(ib1), .in_port2(ib2),
    .chg(chgb), .any_chg(anyb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, settle, and tally chg pulses per channel.
  task automatic tick();
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) if (chg[i]) pulses[i]++;
  endtask

  initial begin
    int p0;
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    resetn = 1'b0;
    sw0 = 6'h2A; sw1 = 6'h00; sw2 = 6'h00;
    swb0 = 6'h00; swb1 = 6'h00; swb2 = 6'h00;

    // Reset state with a nonzero switch already applied
    repeat (3) tick();
    chk("rst_in_port0", 32'(in_port0), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);
    chk("rst_any_chg", 32'(any_chg), 32'h0);

    // sw0=2A held through release: accepted on edge 7
    resetn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("t1_e%0d_in_port0", e), 32'(in_port0), 32'h0);
      chk($sformatf("t1_e%0d_chg", e), 32'(chg), 32'h0);
    end
    tick();
    chk("t1_e7_in_port0", 32'(in_port0), 32'h2A);
    chk("t1_e7_chg", 32'(chg), 32'h1);
    chk("t1_e7_any_chg", 32'(any_chg), 32'h1);
    tick();
    chk("t1_e8_chg", 32'(chg), 32'h0);
    chk("t1_e8_any_chg", 32'(any_chg), 32'h0);
    chk("t1_pulses0", 32'(pulses[0]), 32'd1);

    // 3-cycle glitch on sw1 is rejected
    sw1 = 6'h3F;
    repeat (3) tick();
    sw1 = 6'h00;
    repeat (12) tick();
    chk("t2_in_port1", 32'(in_port1), 32'h0);
    chk("t2_pulses1", 32'(pulses[1]), 32'd0);

    // sw2 chatters every 2 cycles for 12 cycles, then settles at 15
    for (int k = 0; k < 6; k++) begin
      sw2 = (k % 2 == 0) ? 6'h15 : 6'h00;
      repeat (2) tick();
    end
    chk("t3_chatter_in_port2", 32'(in_port2), 32'h0);
    chk("t3_chatter_pulses2", 32'(pulses[2]), 32'd0);
    sw2 = 6'h15;
    repeat (6) tick();
    chk("t3_e6_in_port2", 32'(in_port2), 32'h0);
    tick();
    chk("t3_e7_in_port2", 32'(in_port2), 32'h15);
    chk("t3_e7_chg", 32'(chg), 32'h4);
    repeat (3) tick();
    chk("t3_pulses2", 32'(pulses[2]), 32'd1);

    // Simultaneous change on all three channels
    sw0 = 6'h01; sw1 = 6'h02; sw2 = 6'h04;
    repeat (6) tick();
    chk("t4_e6_ports", {14'h0, in_port2, in_port1, in_port0}, {14'h0, 6'h15, 6'h00, 6'h2A});
    tick();
    chk("t4_e7_ports", {14'h0, in_port2, in_port1, in_port0}, {14'h0, 6'h04, 6'h02, 6'h01});
    chk("t4_e7_chg", 32'(chg), 32'h7);
    chk("t4_e7_any_chg", 32'(any_chg), 32'h1);
    tick();
    chk("t4_e8_chg", 32'(chg), 32'h0);
    chk("t4_e8_any_chg", 32'(any_chg), 32'h0);

    // Async reset two edges into counting on sw0
    sw0 = 6'h3F;
    repeat (5) tick();
    p0 = pulses[0];
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_ports", {14'h0, in_port2, in_port1, in_port0}, 32'h0);
    chk("t5_async_chg", 32'(chg), 32'h0);
    chk("t5_async_any_chg", 32'(any_chg), 32'h0);
    repeat (2) tick();
    chk("t5_hold_ports", {14'h0, in_port2, in_port1, in_port0}, 32'h0);
    chk("t5_hold_pulses0", 32'(pulses[0]), 32'(p0));
    resetn = 1'b1;
    repeat (6) tick();
    chk("t5_e6_ports", {14'h0, in_port2, in_port1, in_port0}, 32'h0);
    tick();
    chk("t5_e7_ports", {14'h0, in_port2, in_port1, in_port0}, {14'h0, 6'h04, 6'h02, 6'h3F});
    chk("t5_e7_chg", 32'(chg), 32'h7);
    tick();
    chk("t5_e8_chg", 32'(chg), 32'h0);
    chk("t5_pulses0", 32'(pulses[0]), 32'(p0 + 1));

    // DEBOUNCE_CYCLES=1: step accepted on edge 4
    chk("t6_idle_ib0", 32'(ib0), 32'h0);
    swb0 = 6'h2A;
    repeat (3) tick();
    chk("t6_e3_ib0", 32'(ib0), 32'h0);
    chk("t6_e3_chgb", 32'(chgb), 32'h0);
    tick();
    chk("t6_e4_ib0", 32'(ib0), 32'h2A);
    chk("t6_e4_chgb", 32'(chgb), 32'h1);
    chk("t6_e4_anyb", 32'(anyb), 32'h1);
    tick();
    chk("t6_e5_chgb", 32'(chgb), 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
